// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end for the shared 8-bit ALU.
// Latches one request, runs the ALU for one cycle and holds a registered response.
`default_nettype none

module alu_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [3:0]       req0_op,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [3:0]       req1_op,
    output logic             req1_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_carry,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_select,
    output logic             alu_en,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_cout
);

    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_NOTA = 4'h6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           state_q;
    logic             last_grant_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [3:0]       op_q;
    logic             id_q;
    logic             alu_en_q;
    logic             rsp_valid_q, rsp_id_q, rsp_carry_q, rsp_zero_q, rsp_err_q;
    logic [WIDTH-1:0] rsp_result_q;

    logic             grant_d;
    logic             accept_d;
    logic [WIDTH-1:0] a_d, b_d;
    logic [3:0]       op_d;

    function automatic logic op_supported(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_NOTA);
    endfunction

    // With both requesters valid, the one not served last time wins.
    always_comb begin
        grant_d = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_d = ~last_grant_q;
        end else if (req1_valid) begin
            grant_d = 1'b1;
        end
    end

    assign req0_ready = (state_q == S_IDLE) && req0_valid && !grant_d;
    assign req1_ready = (state_q == S_IDLE) && req1_valid &&  grant_d;
    assign accept_d   = req0_ready || req1_ready;

    assign a_d  = grant_d ? req1_a  : req0_a;
    assign b_d  = grant_d ? req1_b  : req0_b;
    assign op_d = grant_d ? req1_op : req0_op;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            id_q         <= 1'b0;
            alu_en_q     <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_carry_q  <= 1'b0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_d) begin
                        a_q          <= a_d;
                        b_q          <= b_d;
                        op_q         <= op_d;
                        id_q         <= grant_d;
                        last_grant_q <= grant_d;
                        alu_en_q     <= op_supported(op_d);
                        state_q      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    alu_en_q    <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    rsp_id_q    <= id_q;
                    // Flags come only from the registered capture of this cycle's ALU output.
                    if (op_supported(op_q)) begin
                        rsp_result_q <= alu_out;
                        rsp_carry_q  <= ((op_q == OP_ADD) || (op_q == OP_SUB)) && alu_cout;
                        rsp_zero_q   <= (alu_out == '0);
                        rsp_err_q    <= 1'b0;
                    end else begin
                        rsp_result_q <= '0;
                        rsp_carry_q  <= 1'b0;
                        rsp_zero_q   <= 1'b0;
                        rsp_err_q    <= 1'b1;
                    end
                    state_q <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_select = op_q;
    assign alu_en     = alu_en_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_carry  = rsp_carry_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_err    = rsp_err_q;

endmodule

`default_nettype wire

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester round-robin arbiter and sequencer for the shared 8-bit ALU datapath. It accepts operation requests over valid/ready handshakes and latches the operands. It then drives the ALU for one execute cycle and captures the result plus carry/zero/error flags into a registered response held until acknowledged. It sits between the ALU_8 instance and its clients (e.g. the instruction decoder and the address-generation logic).

## Interface
Parameters:
- WIDTH, 8, operand/result width; must match the ALU word width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- req0_valid  input  1  requester 0 has an operation pending.
- req0_a, req0_b  input  WIDTH  requester 0 operands.
- req0_op  input  4  requester 0 ALU select code.
- req0_ready  output  1  requester 0 accepted this cycle when high with req0_valid.
- req1_valid, req1_a, req1_b, req1_op, req1_ready: same as requester 0.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  consumer takes response.
- rsp_id  output  1  requester that issued the response (0/1).
- rsp_result  output  WIDTH  captured ALU result.
- rsp_carry  output  1  ALU carry out (ADD/SUB only).
- rsp_zero  output  1  result == 0 (valid ops only).
- rsp_err  output  1  op code was not a supported select.
- alu_a, alu_b  output  WIDTH  operands to ALU.
- alu_select  output  4  select to ALU.
- alu_en  output  1  ALU enable.
- alu_out  input  WIDTH  ALU combinational result.
- alu_cout  input  1  ALU combinational carry out.

## Operation
- Supported op codes: 0001 ADD, 0010 SUB (A + ~B + 1; carry=1 means no borrow), 0011 AND, 0100 OR, 0101 XOR, 0110 NOT A. All other codes are errors.
- FSM states: IDLE, EXEC, RESP.
- IDLE: grant computed combinationally; reqN_ready = (state==IDLE) & grant==N & reqN_valid. At most one ready high per cycle. On accept: latch a, b, op, id into operand registers; update last_grant = id; go EXEC.
- Round robin: only one valid -> grant it. Both valid -> grant the requester != last_grant. last_grant resets to 1, so requester 0 wins the first contention.
- EXEC (exactly one cycle): alu_en = 1 for valid op, 0 for error op. At cycle end, capture response: valid op -> rsp_result = alu_out, rsp_carry = alu_cout for ADD/SUB else 0, rsp_zero = (alu_out==0), rsp_err = 0. Error op -> rsp_result = 0, rsp_carry = 0, rsp_zero = 0, rsp_err = 1. Go RESP.
- RESP: rsp_valid = 1. All rsp_* held stable until rsp_ready sampled high. Then go IDLE, rsp_valid drops next cycle. No request accepted in EXEC or RESP; requester valids must be held, and pending valids are not lost.
- alu_a/alu_b/alu_select always reflect the latched operand registers; alu_en high only in EXEC.
- Requests' operands are don't-care when valid is low.

## Timing
- Reset (rst high at a clock edge): state IDLE; last_grant = 1; all outputs 0 (req*_ready, rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_zero, rsp_err, alu_a, alu_b, alu_select, alu_en). Reset overrides everything.
- Reset mid-operation (EXEC or RESP): transaction dropped, no response emitted, original requester must re-issue.
- Accept at edge T -> EXEC during cycle T+1 (alu_en=1) -> rsp_valid high from cycle T+2.
- With rsp_ready held high: rsp_valid for one cycle (T+2), IDLE at T+3. Next accept at earliest edge T+3, giving a minimum of 3 cycles per operation.
- rsp_ready low: RESP persists indefinitely, outputs frozen.
- rsp_ready high in IDLE/EXEC is ignored.
- Simultaneous valids on both ports resolve in the same cycle; the loser is accepted in the next IDLE cycle if still valid.
- Carry/zero derive only from the EXEC-cycle ALU outputs; no combinational path from alu_out to rsp_*.

## Test plan
- Reset: assert rst 2 cycles mid-EXEC -> all outputs 0 next cycle, no rsp_valid, last_grant=1.
- ADD wrap: req0 ADD a=0xFF b=0x01 -> rsp_valid 2 cycles after accept, rsp_id=0, result 0x00, carry 1, zero 1, err 0.
- SUB borrow: req1 SUB 0x05-0x07 -> result 0xFE, carry 0, zero 0. SUB 0x07-0x05 -> result 0x02, carry 1.
- Contention: both valid continuously, each issuing AND 0xF0&0x3C -> grants alternate 0,1,0,1. Every result 0x30, carry 0. Each op spans 3 cycles with rsp_ready high.
- Backpressure: rsp_ready low 5 cycles after rsp_valid -> rsp_* stable, req*_ready stay 0. Raise rsp_ready -> IDLE next cycle, pending request accepted.
- Error op: req0 op=1111 a=0x12 -> alu_en stays 0 in EXEC, rsp_err 1, result 0x00, carry 0, zero 0. NOT A with a=0xFF -> result 0x00, zero 1, carry 0.
